// File: rtl/seq_div_unit.sv
// Radix-2 restoring divider, one quotient bit per cycle, with start/busy/done handshake.
// Optional signed operation is enabled by defining SIGNED_DIV_EN.
module seq_div_unit #(
   parameter int unsigned DW = 32,
   parameter int unsigned VW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
`ifdef SIGNED_DIV_EN
   input  logic          signed_mode,
`endif
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          div_by_zero
);

   localparam int unsigned CW = $clog2(DW);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_NEG, S_FIN} state_t;

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_count, w_count_nxt;
   logic [VW-1:0] r_p, w_p_nxt;
   logic [DW-1:0] r_q, w_q_nxt;
   logic [VW-1:0] r_div, w_div_nxt;
   logic          r_busy, w_busy_nxt;
   logic          r_done, w_done_nxt;
   logic [DW-1:0] r_quot, w_quot_nxt;
   logic [VW-1:0] r_rem, w_rem_nxt;
   logic          r_dbz, w_dbz_nxt;

   logic [VW:0]   w_t;
   logic          w_ge;
   logic [VW-1:0] w_p_step;
   logic [DW-1:0] w_q_step;
   logic [DW-1:0] w_dvd_mag;
   logic [VW-1:0] w_dvs_mag;

`ifdef SIGNED_DIV_EN
   logic r_neg_q, w_neg_q_nxt;
   logic r_neg_r, w_neg_r_nxt;

   assign w_dvd_mag = (signed_mode && dividend[DW-1]) ? -dividend : dividend;
   assign w_dvs_mag = (signed_mode && divisor[VW-1])  ? -divisor  : divisor;
`else
   assign w_dvd_mag = dividend;
   assign w_dvs_mag = divisor;
`endif

   // One restoring step; the partial remainder stays below the divisor, so VW bits hold it
   assign w_t      = {r_p, r_q[DW-1]};
   assign w_ge     = (w_t >= {1'b0, r_div});
   assign w_p_step = w_ge ? VW'(w_t - {1'b0, r_div}) : w_t[VW-1:0];
   assign w_q_step = {r_q[DW-2:0], w_ge};

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_p_nxt     = r_p;
      w_q_nxt     = r_q;
      w_div_nxt   = r_div;
      w_quot_nxt  = r_quot;
      w_rem_nxt   = r_rem;
      w_dbz_nxt   = r_dbz;
`ifdef SIGNED_DIV_EN
      w_neg_q_nxt = r_neg_q;
      w_neg_r_nxt = r_neg_r;
`endif
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (divisor == '0) begin
                  w_state_nxt = S_FIN;
                  w_quot_nxt  = '1;
                  w_rem_nxt   = dividend[VW-1:0];
                  w_dbz_nxt   = 1'b1;
               end else begin
                  w_state_nxt = S_RUN;
                  w_count_nxt = CW'(DW - 1);
                  w_p_nxt     = '0;
                  w_q_nxt     = w_dvd_mag;
                  w_div_nxt   = w_dvs_mag;
`ifdef SIGNED_DIV_EN
                  w_neg_q_nxt = signed_mode & (dividend[DW-1] ^ divisor[VW-1]);
                  w_neg_r_nxt = signed_mode & dividend[DW-1];
`endif
               end
            end
         end
         S_RUN: begin
            w_p_nxt = w_p_step;
            w_q_nxt = w_q_step;
            if (r_count == '0) begin
`ifdef SIGNED_DIV_EN
               w_state_nxt = S_NEG;
`else
               w_state_nxt = S_FIN;
               w_quot_nxt  = w_q_step;
               w_rem_nxt   = w_p_step;
               w_dbz_nxt   = 1'b0;
`endif
            end else begin
               w_count_nxt = r_count - CW'(1);
            end
         end
`ifdef SIGNED_DIV_EN
         // Sign fix-up: quotient truncates toward zero, remainder follows the dividend
         S_NEG: begin
            w_state_nxt = S_FIN;
            w_quot_nxt  = r_neg_q ? -r_q : r_q;
            w_rem_nxt   = r_neg_r ? -r_p : r_p;
            w_dbz_nxt   = 1'b0;
         end
`endif
         S_FIN:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      w_busy_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_NEG);
      w_done_nxt = (w_state_nxt == S_FIN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_count <= '0;
         r_p     <= '0;
         r_q     <= '0;
         r_div   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_quot  <= '0;
         r_rem   <= '0;
         r_dbz   <= 1'b0;
`ifdef SIGNED_DIV_EN
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         r_p     <= w_p_nxt;
         r_q     <= w_q_nxt;
         r_div   <= w_div_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_quot  <= w_quot_nxt;
         r_rem   <= w_rem_nxt;
         r_dbz   <= w_dbz_nxt;
`ifdef SIGNED_DIV_EN
         r_neg_q <= w_neg_q_nxt;
         r_neg_r <= w_neg_r_nxt;
`endif
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign quotient    = r_quot;
   assign remainder   = r_rem;
   assign div_by_zero = r_dbz;

endmodule
